// File: rtl/sprite_fb_writer.sv
// Write-side client of the double-buffered frame manager: on grant of its source slot it
// sweeps one sprite out of a synchronous bitmap ROM into the back framebuffer, one pixel per clock.
module sprite_fb_writer #(
  parameter int SOURCE_ID         = 0,
  parameter int SOURCE_SEL_ADDRW  = 2,
  parameter int COLOR_DEPTH       = 8,
  parameter int DRAW_WIDTH        = 640,
  parameter int DRAW_HEIGHT       = 480,
  parameter int DRAW_WIDTH_ADDRW  = 10,
  parameter int DRAW_HEIGHT_ADDRW = 9,
  parameter int SCALE_DOWN_FACTOR = 2,
  parameter int SPRITE_W          = 16,
  parameter int SPRITE_H          = 16,
  parameter int TRANSPARENT_COLOR = 0,
  localparam int ROM_AW = (SPRITE_W * SPRITE_H > 1) ? $clog2(SPRITE_W * SPRITE_H) : 1
) (
  input  logic                         write_clk,
  input  logic                         resetN,
  input  logic                         enable,
  input  logic [DRAW_WIDTH_ADDRW-1:0]  obj_x,
  input  logic [DRAW_HEIGHT_ADDRW-1:0] obj_y,
  input  logic                         write_awaited,
  input  logic [SOURCE_SEL_ADDRW-1:0]  write_source_sel,
  output logic [ROM_AW-1:0]            rom_addr,
  input  logic [COLOR_DEPTH-1:0]       rom_data,
  output logic                         write_active,
  output logic [DRAW_WIDTH_ADDRW-1:0]  write_x_addr,
  output logic [DRAW_HEIGHT_ADDRW-1:0] write_y_addr,
  output logic [COLOR_DEPTH-1:0]       write_color_data,
  output logic                         write_transparent,
  output logic [1:0]                   dbg_state
);

  localparam int SHR = $clog2(SCALE_DOWN_FACTOR);
  localparam int PXW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int PYW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam int XW  = DRAW_WIDTH_ADDRW + 1;
  localparam int YW  = DRAW_HEIGHT_ADDRW + 1;

  localparam logic [PXW-1:0]              PX_LAST = PXW'(SPRITE_W - 1);
  localparam logic [PYW-1:0]              PY_LAST = PYW'(SPRITE_H - 1);
  localparam logic [XW-1:0]               X_LIMIT = XW'(DRAW_WIDTH);
  localparam logic [YW-1:0]               Y_LIMIT = YW'(DRAW_HEIGHT);
  localparam logic [SOURCE_SEL_ADDRW-1:0] MY_SRC  = SOURCE_SEL_ADDRW'(SOURCE_ID);
  localparam logic [COLOR_DEPTH-1:0]      TRANSP  = COLOR_DEPTH'(TRANSPARENT_COLOR);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SWEEP   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [PXW-1:0]               px;
  logic [PYW-1:0]               py;
  logic [DRAW_WIDTH_ADDRW-1:0]  ox_lat;
  logic [DRAW_HEIGHT_ADDRW-1:0] oy_lat;
  logic                         en_lat;
  logic [XW-1:0]                x_wide;
  logic [YW-1:0]                y_wide;
  logic                         clip;
  logic                         tr_q;
  logic                         grant;
  logic                         last_px;

  assign grant   = (state_q == IDLE) && write_awaited && (write_source_sel == MY_SRC);
  assign last_px = (px == PX_LAST) && (py == PY_LAST);

  assign rom_addr = ROM_AW'(py) * ROM_AW'(SPRITE_W) + ROM_AW'(px);
  assign x_wide   = {1'b0, ox_lat} + (XW'(px) << SHR);
  assign y_wide   = {1'b0, oy_lat} + (YW'(py) << SHR);
  assign clip     = (x_wide >= X_LIMIT) || (y_wide >= Y_LIMIT);

  assign write_color_data  = rom_data;
  assign write_transparent = tr_q | (rom_data == TRANSP);
  assign dbg_state         = state_q;

  always_ff @(posedge write_clk or negedge resetN) begin
    if (!resetN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // RELEASE waits for write_awaited to fall so a lingering request cannot re-grant.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = SWEEP;
      SWEEP:   if (last_px || !en_lat) state_d = RELEASE;
      RELEASE: if (!write_active && !write_awaited) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge write_clk or negedge resetN) begin
    if (!resetN) begin
      px     <= '0;
      py     <= '0;
      ox_lat <= '0;
      oy_lat <= '0;
      en_lat <= 1'b0;
    end else if (grant) begin
      px     <= '0;
      py     <= '0;
      ox_lat <= obj_x;
      oy_lat <= obj_y;
      en_lat <= enable;
    end else if (state_q == SWEEP) begin
      if (last_px || !en_lat) begin
        px <= '0;
        py <= '0;
      end else if (px == PX_LAST) begin
        px <= '0;
        py <= py + 1'b1;
      end else begin
        px <= px + 1'b1;
      end
    end
  end

  // Output stage lines up with the ROM's one-clock read latency.
  always_ff @(posedge write_clk or negedge resetN) begin
    if (!resetN) begin
      write_active <= 1'b0;
      write_x_addr <= '0;
      write_y_addr <= '0;
      tr_q         <= 1'b1;
    end else begin
      write_active <= (state_q == SWEEP);
      if (state_q == SWEEP) begin
        write_x_addr <= x_wide[DRAW_WIDTH_ADDRW-1:0];
        write_y_addr <= y_wide[DRAW_HEIGHT_ADDRW-1:0];
        tr_q         <= ~en_lat | clip;
      end else begin
        tr_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sprite_fb_writer.sv
// Bench for sprite_fb_writer: 2x2 sprite, downscale 2, 640x480 draw area, source slot 1.
module tb_sprite_fb_writer;

  localparam int SRC = 1;
  localparam int W   = 28;  // {x[9:0], y[8:0], color[7:0], transparent}

  logic       clk;
  logic       resetN;
  logic       enable;
  logic [9:0] obj_x;
  logic [8:0] obj_y;
  logic       write_awaited;
  logic [1:0] write_source_sel;
  logic [1:0] rom_addr;
  logic [7:0] rom_data;
  logic       write_active;
  logic [9:0] write_x_addr;
  logic [8:0] write_y_addr;
  logic [7:0] write_color_data;
  logic       write_transparent;
  logic [1:0] dbg_state;

  logic [7:0]   rom[4];
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_bad    = 0;
  int           act_cnt  = 0;

  typedef struct {
    int         ox;
    int         oy;
    bit         en;
    logic [7:0] img[4];
    int         exp_len;
  } vec_t;

  vec_t vecs[6];

  sprite_fb_writer #(
    .SOURCE_ID(SRC), .SOURCE_SEL_ADDRW(2), .COLOR_DEPTH(8),
    .DRAW_WIDTH(640), .DRAW_HEIGHT(480), .DRAW_WIDTH_ADDRW(10), .DRAW_HEIGHT_ADDRW(9),
    .SCALE_DOWN_FACTOR(2), .SPRITE_W(2), .SPRITE_H(2), .TRANSPARENT_COLOR(0)
  ) dut (
    .write_clk(clk), .resetN(resetN), .enable(enable), .obj_x(obj_x), .obj_y(obj_y),
    .write_awaited(write_awaited), .write_source_sel(write_source_sel),
    .rom_addr(rom_addr), .rom_data(rom_data), .write_active(write_active),
    .write_x_addr(write_x_addr), .write_y_addr(write_y_addr),
    .write_color_data(write_color_data), .write_transparent(write_transparent),
    .dbg_state(dbg_state)
  );

  // clock / reset / ROM model
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) rom_data <= rom[rom_addr];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: pixels in row-major order, disabled grant emits one forced-transparent pixel
  task automatic push_expected(input int ox, input int oy, input bit en);
    int         x;
    int         y;
    bit         clipped;
    logic [7:0] c;
    if (!en) begin
      x = ox;
      y = oy;
      exp_q.push_back({x[9:0], y[8:0], rom[0], 1'b1});
    end else begin
      for (int py = 0; py < 2; py++) begin
        for (int px = 0; px < 2; px++) begin
          x       = ox + px * 2;
          y       = oy + py * 2;
          clipped = (x >= 640) || (y >= 480);
          c       = rom[py * 2 + px];
          exp_q.push_back({x[9:0], y[8:0], c, clipped || (c == 8'd0)});
        end
      end
    end
  endtask

  // scoreboard: every active cycle pops one expected pixel
  always @(negedge clk) begin
    if (resetN && write_active === 1'b1) begin
      act_cnt++;
      if (exp_q.size() == 0) begin
        check("pixel_queue_nonempty", exp_q.size(), 1);
      end else begin
        check("pixel", {write_x_addr, write_y_addr, write_color_data, write_transparent},
              exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic load_rom(input logic [7:0] img[4]);
    for (int i = 0; i < 4; i++) rom[i] = img[i];
  endtask

  task automatic run_burst(input int ox, input int oy, input bit en, input int exp_len);
    @(negedge clk);
    obj_x            = ox[9:0];
    obj_y            = oy[8:0];
    enable           = en;
    write_source_sel = 2'(SRC);
    write_awaited    = 1'b1;
    push_expected(ox, oy, en);
    act_cnt = 0;
    @(negedge clk);
    // post-grant changes must not reach this burst
    obj_x  = obj_x + 10'd100;
    obj_y  = obj_y + 9'd3;
    enable = ~en;
    check("grant_state", dbg_state, 1);
    check("active_before_rise", write_active, 0);
    @(negedge clk);
    check("active_rise", write_active, 1);
    repeat (2) @(negedge clk);
    write_awaited = 1'b0;
    for (int i = 0; i < 100 && write_active; i++) @(negedge clk);
    check("burst_end", write_active, 0);
    check("burst_len", act_cnt, exp_len);
    repeat (3) @(negedge clk);
    check("back_idle", dbg_state, 0);
    check("no_retrigger", act_cnt, exp_len);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic set_vec(input int i, input int ox, input int oy, input bit en,
                         input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2,
                         input logic [7:0] r3, input int len);
    vecs[i].ox      = ox;
    vecs[i].oy      = oy;
    vecs[i].en      = en;
    vecs[i].img[0]  = r0;
    vecs[i].img[1]  = r1;
    vecs[i].img[2]  = r2;
    vecs[i].img[3]  = r3;
    vecs[i].exp_len = len;
  endtask

  initial begin
    logic [7:0] img[4];

    set_vec(0,  10,  20, 1'b1, 8'd5, 8'd6, 8'd7, 8'd8, 4);   // basic sweep
    set_vec(1,  10,  20, 1'b1, 8'd5, 8'd0, 8'd7, 8'd8, 4);   // transparent ROM entry
    set_vec(2, 638,  20, 1'b1, 8'd1, 8'd2, 8'd3, 8'd4, 4);   // right-edge clip
    set_vec(3, 100, 479, 1'b1, 8'd9, 8'd9, 8'd9, 8'd9, 4);   // bottom-edge clip
    set_vec(4,  50,  60, 1'b0, 8'd3, 8'd4, 8'd5, 8'd6, 1);   // disabled grant
    set_vec(5,   0,   0, 1'b1, 8'd255, 8'd1, 8'd2, 8'd3, 4); // origin

    resetN           = 1'b0;
    enable           = 1'b0;
    obj_x            = '0;
    obj_y            = '0;
    write_awaited    = 1'b0;
    write_source_sel = '0;
    for (int i = 0; i < 4; i++) rom[i] = 8'd1;
    repeat (3) @(negedge clk);
    check("rst_active", write_active, 0);
    check("rst_x", write_x_addr, 0);
    check("rst_y", write_y_addr, 0);
    check("rst_transparent", write_transparent, 1);
    check("rst_state", dbg_state, 0);
    check("rst_rom_addr", rom_addr, 0);
    resetN = 1'b1;

    // another source selected: this instance must stay quiet
    @(negedge clk);
    write_awaited    = 1'b1;
    write_source_sel = 2'(SRC + 1);
    act_cnt          = 0;
    repeat (50) @(negedge clk);
    check("foreign_sel_active", act_cnt, 0);
    check("foreign_sel_state", dbg_state, 0);
    check("foreign_sel_transparent", write_transparent, 1);

    for (int v = 0; v < 6; v++) begin
      load_rom(vecs[v].img);
      run_burst(vecs[v].ox, vecs[v].oy, vecs[v].en, vecs[v].exp_len);
    end

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) img[i] = 8'($urandom_range(0, 3));
      load_rom(img);
      run_burst($urandom_range(0, 639), $urandom_range(0, 479), 1'b1, 4);
    end

    // reset in the middle of a burst, then a clean burst from pixel 0
    img[0] = 8'd21; img[1] = 8'd22; img[2] = 8'd23; img[3] = 8'd24;
    load_rom(img);
    @(negedge clk);
    obj_x            = 10'd30;
    obj_y            = 9'd40;
    enable           = 1'b1;
    write_source_sel = 2'(SRC);
    write_awaited    = 1'b1;
    push_expected(30, 40, 1'b1);
    repeat (4) @(negedge clk);
    check("mid_burst_active", write_active, 1);
    #2;
    resetN        = 1'b0;
    write_awaited = 1'b0;
    #1;
    check("async_rst_active", write_active, 0);
    check("async_rst_transparent", write_transparent, 1);
    check("async_rst_x", write_x_addr, 0);
    check("async_rst_state", dbg_state, 0);
    check("pixels_left_at_reset", exp_q.size(), 1);
    exp_q.delete();
    @(negedge clk);
    resetN = 1'b1;
    img[0] = 8'd31; img[1] = 8'd32; img[2] = 8'd33; img[3] = 8'd34;
    load_rom(img);
    run_burst(30, 40, 1'b1, 4);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
